// File: rtl/spmv_csr_engine_pkg.sv
// Shared types and constants for the CSR sparse-matrix x vector engine.
// FSM encodings, FP16 special values and default pointer width.
package spmv_csr_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3
   } state_t;

   localparam logic [15:0] FP16_ZERO = 16'h0000;
   localparam logic [15:0] FP16_INF  = 16'h7C00;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;

   localparam int PTR_W_DEF = 8;

endpackage

// File: rtl/SpMV_fp16_add.sv
// FP16 adder, round-to-nearest-even, one register stage.
// Ports: i_clk, i_rstn, a, b (operands), y (registered sum).
module SpMV_fp16_add
   import spmv_csr_engine_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic [15:0] big, sml;
   logic [4:0]  d;
   logic [13:0] mb, ms, smsh, sm, nrm;
   logic [29:0] shf;
   logic        stk;
   logic [14:0] sum;
   logic [3:0]  lz;
   logic [10:0] rnd;
   int          e;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [15:0] res;

   always_comb begin
      a_zero = (a[14:10] == 5'd0);
      b_zero = (b[14:10] == 5'd0);
      a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      big    = (b[14:0] > a[14:0]) ? b : a;
      sml    = (b[14:0] > a[14:0]) ? a : b;
      d      = big[14:10] - sml[14:10];
      // three extra bits: guard, round, sticky
      mb     = {1'b1, big[9:0], 3'b000};
      ms     = {1'b1, sml[9:0], 3'b000};
      shf    = {ms, 16'd0} >> d;
      smsh   = d[4] ? 14'd0 : shf[29:16];
      stk    = d[4] ? 1'b1 : (|shf[15:0]);
      sm     = {smsh[13:1], smsh[0] | stk};
      if (big[15] ^ sml[15]) sum = {1'b0, mb} - {1'b0, sm};
      else                   sum = {1'b0, mb} + {1'b0, sm};
      lz = 4'd0;
      for (int i = 0; i < 14; i++)
         if (sum[i]) lz = 4'(13 - i);
      if (sum[14]) begin
         nrm = {sum[14:2], sum[1] | sum[0]};
         e   = int'(big[14:10]) + 1;
      end else begin
         nrm = sum[13:0] << lz;
         e   = int'(big[14:10]) - int'(lz);
      end
      rnd = {1'b0, nrm[12:3]}
          + 11'(nrm[2] & ((|nrm[1:0]) | nrm[3]));
      e   = e + int'(rnd[10]);
      res = FP16_ZERO;
      if (a_nan || b_nan)
         res = FP16_QNAN;
      else if (a_inf && b_inf && (a[15] != b[15]))
         res = FP16_QNAN;
      else if (a_inf)
         res = a;
      else if (b_inf)
         res = b;
      else if (a_zero && b_zero)
         res = {a[15] & b[15], 15'd0};
      else if (a_zero)
         res = b;
      else if (b_zero)
         res = a;
      else if (sum == 15'd0)
         res = FP16_ZERO;
      else if (e >= 31)
         res = {big[15], FP16_INF[14:0]};
      else if (e <= 0)
         res = {big[15], 15'd0};
      else
         res = {big[15], 5'(e), rnd[9:0]};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) y <= FP16_ZERO;
      else         y <= res;
   end

endmodule

// File: rtl/SpMV_fp16_mul.sv
// FP16 multiplier, round-to-nearest-even, one register stage.
// Ports: i_clk, i_rstn, a, b (operands), y (registered product).
module SpMV_fp16_mul
   import spmv_csr_engine_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic        sgn;
   logic [21:0] prod;
   logic        norm;
   logic [9:0]  mant;
   logic        g;
   logic        st;
   logic [10:0] rnd;
   int          e;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [15:0] res;

   always_comb begin
      sgn    = a[15] ^ b[15];
      // subnormal inputs are flushed to zero
      a_zero = (a[14:10] == 5'd0);
      b_zero = (b[14:10] == 5'd0);
      a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      prod   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      norm   = prod[21];
      mant   = norm ? prod[20:11] : prod[19:10];
      g      = norm ? prod[10] : prod[9];
      st     = norm ? (|prod[9:0]) : (|prod[8:0]);
      rnd    = {1'b0, mant} + 11'(g & (st | mant[0]));
      e      = int'(a[14:10]) + int'(b[14:10]) - 15
             + int'(norm) + int'(rnd[10]);
      res    = FP16_ZERO;
      if (a_nan || b_nan)
         res = FP16_QNAN;
      else if (a_inf)
         res = b_zero ? FP16_QNAN : {sgn, FP16_INF[14:0]};
      else if (b_inf)
         res = a_zero ? FP16_QNAN : {sgn, FP16_INF[14:0]};
      else if (a_zero || b_zero)
         res = {sgn, 15'd0};
      else if (e >= 31)
         res = {sgn, FP16_INF[14:0]};
      else if (e <= 0)
         res = {sgn, 15'd0};
      else
         res = {sgn, 5'(e), rnd[9:0]};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) y <= FP16_ZERO;
      else         y <= res;
   end

endmodule

// File: rtl/spmv_row_lookup.sv
// Maps beat index k to its CSR row: smallest i with ptr[i] <= k < ptr[i+1].
// Ports: row_ptr (flat pointer table), k (beat index), row (row index).
module spmv_row_lookup
   import spmv_csr_engine_pkg::*;
#(
   parameter int N_ROWS = 16,
   parameter int PTR_W  = PTR_W_DEF
) (
   input  logic [(N_ROWS+1)*PTR_W-1:0] row_ptr,
   input  logic [PTR_W-1:0]            k,
   output logic [$clog2(N_ROWS)-1:0]   row
);

   // descending scan so the lowest matching row wins; empty rows never match
   always_comb begin
      row = '0;
      for (int i = N_ROWS - 1; i >= 0; i--)
         if (row_ptr[i*PTR_W +: PTR_W] <= k &&
             k < row_ptr[(i+1)*PTR_W +: PTR_W])
            row = ($clog2(N_ROWS))'(i);
   end

endmodule

// File: rtl/spmv_csr_engine.sv
// CSR SpMV engine in FP16: y[row] (+)= A * x, one nonzero per cycle.
// Ports: i_clk, i_rstn, i_start, i_accum, i_row_ptr, i_nz_valid/o_nz_ready,
//   i_mat_value, i_in_vector, o_state, o_busy, o_done, o_err, o_result.
module spmv_csr_engine
   import spmv_csr_engine_pkg::*;
#(
   parameter int N_ROWS = 16,
   parameter int DATA_W = 16,
   parameter int PTR_W  = PTR_W_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic                        i_start,
   input  logic                        i_accum,
   input  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr,
   input  logic                        i_nz_valid,
   output logic                        o_nz_ready,
   input  logic [DATA_W-1:0]           i_mat_value,
   input  logic [DATA_W-1:0]           i_in_vector,
   output logic [2:0]                  o_state,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err,
   output logic [N_ROWS*DATA_W-1:0]    o_result
);

   localparam int RW = $clog2(N_ROWS);

   state_t state_q, state_d;

   logic [(N_ROWS+1)*PTR_W-1:0] rp_q;
   logic [PTR_W-1:0]  k_q, nnz_q, start_nnz;
   logic              drain_q, err_q;
   logic [DATA_W-1:0] y_q [N_ROWS];
   logic              s1_v_q, s2_v_q;
   logic [RW-1:0]     s1_row_q, s2_row_q, beat_row;
   logic [DATA_W-1:0] mul_y, add_y, add_b;
   logic              malformed, accept, last_beat;

   assign start_nnz = i_row_ptr[N_ROWS*PTR_W +: PTR_W];

   always_comb begin
      malformed = (i_row_ptr[0 +: PTR_W] != '0);
      for (int i = 0; i < N_ROWS; i++)
         if (i_row_ptr[i*PTR_W +: PTR_W] >
             i_row_ptr[(i+1)*PTR_W +: PTR_W])
            malformed = 1'b1;
   end

   assign o_nz_ready = (state_q == ST_RUN);
   assign accept     = o_nz_ready && i_nz_valid;
   assign last_beat  = (k_q == nnz_q - PTR_W'(1));

   spmv_row_lookup #(
      .N_ROWS (N_ROWS),
      .PTR_W  (PTR_W)
   ) u_lookup (
      .row_ptr (rp_q),
      .k       (k_q),
      .row     (beat_row)
   );

   SpMV_fp16_mul u_mul (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .a      (i_mat_value),
      .b      (i_in_vector),
      .y      (mul_y)
   );

   // S2 holds a sum for the same row that y has not absorbed yet
   assign add_b = (s2_v_q && s2_row_q == s1_row_q) ? add_y
                                                   : y_q[s1_row_q];

   SpMV_fp16_add u_add (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .a      (mul_y),
      .b      (add_b),
      .y      (add_y)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (i_start)
               state_d = (malformed || start_nnz == '0) ? ST_DONE
                                                        : ST_RUN;
         ST_RUN:
            if (accept && last_beat) state_d = ST_DRAIN;
         ST_DRAIN:
            if (drain_q) state_d = ST_DONE;
         ST_DONE:
            state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= ST_IDLE;
         rp_q     <= '0;
         k_q      <= '0;
         nnz_q    <= '0;
         drain_q  <= 1'b0;
         err_q    <= 1'b0;
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s1_row_q <= '0;
         s2_row_q <= '0;
         for (int i = 0; i < N_ROWS; i++) y_q[i] <= FP16_ZERO;
      end else begin
         state_q <= state_d;
         s1_v_q  <= accept;
         if (accept) begin
            s1_row_q <= beat_row;
            k_q      <= k_q + PTR_W'(1);
         end
         s2_v_q   <= s1_v_q;
         s2_row_q <= s1_row_q;
         if (s2_v_q) y_q[s2_row_q] <= add_y;
         drain_q <= (state_q == ST_DRAIN) && !drain_q;
         if (state_q == ST_IDLE && i_start) begin
            rp_q  <= i_row_ptr;
            nnz_q <= start_nnz;
            k_q   <= '0;
            err_q <= malformed;
            if (!malformed && !i_accum)
               for (int i = 0; i < N_ROWS; i++) y_q[i] <= FP16_ZERO;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_ROWS; gi++) begin : g_res
         assign o_result[gi*DATA_W +: DATA_W] = y_q[gi];
      end
   endgenerate

   assign o_state = state_q;
   assign o_busy  = (state_q != ST_IDLE);
   assign o_done  = (state_q == ST_DONE);
   assign o_err   = err_q;

endmodule

// File: tb/tb_spmv_csr_engine.sv
// Scoreboard bench for spmv_csr_engine: real-arithmetic FP16 model,
// directed CSR jobs plus randomized jobs with valid gaps.
module tb_spmv_csr_engine;

   localparam int NR = 16;
   localparam int DW = 16;
   localparam int PW = 8;

   logic                   i_clk = 1'b0;
   logic                   i_rstn = 1'b0;
   logic                   i_start = 1'b0;
   logic                   i_accum = 1'b0;
   logic [(NR+1)*PW-1:0]   i_row_ptr = '0;
   logic                   i_nz_valid = 1'b0;
   logic                   o_nz_ready;
   logic [DW-1:0]          i_mat_value = '0;
   logic [DW-1:0]          i_in_vector = '0;
   logic [2:0]             o_state;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_err;
   logic [NR*DW-1:0]       o_result;

   spmv_csr_engine #(.N_ROWS(NR), .DATA_W(DW), .PTR_W(PW)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_start     (i_start),
      .i_accum     (i_accum),
      .i_row_ptr   (i_row_ptr),
      .i_nz_valid  (i_nz_valid),
      .o_nz_ready  (o_nz_ready),
      .i_mat_value (i_mat_value),
      .i_in_vector (i_in_vector),
      .o_state     (o_state),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_result    (o_result)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int               cyc;
      logic             err;
      logic [NR*DW-1:0] y;
   } exp_t;

   exp_t        sbq[$];
   int          rstq[$];
   int          checks = 0;
   int          errors = 0;
   logic        no_ready_win = 1'b0;
   logic [15:0] my [NR];
   int          rp [NR+1];
   logic [15:0] ba[$];
   logic [15:0] bx[$];

   function automatic real to_real(input logic [15:0] h);
      real r;
      int  e;
      if (h[14:10] == 5'd0) return 0.0;
      r = 1.0 + real'(h[9:0]) / 1024.0;
      e = int'(h[14:10]) - 15;
      for (int i = 0; i < e; i++) r = r * 2.0;
      for (int i = 0; i > e; i--) r = r / 2.0;
      return h[15] ? -r : r;
   endfunction

   // exact value -> nearest FP16, ties to even (normal range only)
   function automatic logic [15:0] to_fp16(input real r);
      logic s;
      real  a, m, f;
      int   e, mi;
      if (r == 0.0) return 16'h0000;
      s = (r < 0.0);
      a = s ? -r : r;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      m  = (a - 1.0) * 1024.0;
      mi = $rtoi(m);
      f  = m - real'(mi);
      if (f > 0.5 || (f == 0.5 && (mi % 2) == 1)) mi++;
      if (mi == 1024) begin mi = 0; e++; end
      return {s, 5'(e + 15), 10'(mi)};
   endfunction

   function automatic int row_of(input int k);
      for (int i = 0; i < NR; i++)
         if (rp[i] <= k && k < rp[i+1]) return i;
      return 0;
   endfunction

   function automatic logic [NR*DW-1:0] pack_y();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = my[i];
      return v;
   endfunction

   function automatic logic [15:0] rnd_fp();
      logic [15:0] v;
      v = {1'($urandom_range(1, 0)), 5'($urandom_range(16, 13)),
           10'($urandom)};
      return v;
   endfunction

   task automatic check(input string nm, input logic [255:0] act,
                        input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge i_clk) begin
      exp_t e;
      if (rstq.size() != 0) begin
         void'(rstq.pop_front());
         check("rst_state", 256'(o_state), 256'(0));
         check("rst_busy", 256'(o_busy), 256'(0));
         check("rst_done", 256'(o_done), 256'(0));
         check("rst_err", 256'(o_err), 256'(0));
         check("rst_result", 256'(o_result), 256'(0));
      end
      if (no_ready_win) check("no_ready", 256'(o_nz_ready), 256'(0));
      if (o_done) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", 256'(o_done), 256'(0));
         end else begin
            e = sbq.pop_front();
            check("done_cycle", 256'(cyc), 256'(e.cyc));
            check("err", 256'(o_err), 256'(e.err));
            for (int i = 0; i < NR; i++)
               check($sformatf("y%0d", i), 256'(o_result[i*DW +: DW]),
                     256'(e.y[i*DW +: DW]));
         end
      end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         check("done_late", 256'(o_done), 256'(1));
      end
   end

   task automatic send_beat(input logic [15:0] a, input logic [15:0] x);
      int w;
      i_mat_value = a;
      i_in_vector = x;
      i_nz_valid  = 1'b1;
      w = 0;
      @(negedge i_clk);
      while (!o_nz_ready) begin
         w++;
         if (w > 20) begin
            $display("FAIL nz_ready_timeout: got 0 expected 1");
            $fatal(1, "no ready");
         end
         @(negedge i_clk);
      end
      @(posedge i_clk);
      #1;
      i_nz_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 200 && sbq.size() != 0; t++) @(posedge i_clk);
   endtask

   task automatic start_job(input logic acc);
      @(posedge i_clk);
      #1;
      for (int i = 0; i <= NR; i++) i_row_ptr[i*PW +: PW] = PW'(rp[i]);
      i_start = 1'b1;
      i_accum = acc;
   endtask

   task automatic run_job(input logic acc, input int gapmax);
      logic bad;
      int   nnz, g, r;
      exp_t e;
      bad = (rp[0] != 0);
      for (int i = 0; i < NR; i++) if (rp[i] > rp[i+1]) bad = 1'b1;
      nnz = rp[NR];
      wait_idle();
      start_job(acc);
      if (!bad && !acc) for (int i = 0; i < NR; i++) my[i] = 16'h0000;
      if (bad || nnz == 0) begin
         e.cyc = cyc + 1;
         e.err = bad;
         e.y   = pack_y();
         sbq.push_back(e);
         no_ready_win = 1'b1;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      if (bad || nnz == 0) begin
         repeat (3) @(posedge i_clk);
         #1;
         no_ready_win = 1'b0;
      end else begin
         for (int k = 0; k < nnz; k++) begin
            g = $urandom_range(gapmax, 0);
            repeat (g) begin @(posedge i_clk); #1; end
            send_beat(ba[k], bx[k]);
            r = row_of(k);
            my[r] = to_fp16(to_real(my[r]) +
                    to_real(to_fp16(to_real(ba[k]) * to_real(bx[k]))));
         end
         e.cyc = cyc + 2;
         e.err = 1'b0;
         e.y   = pack_y();
         sbq.push_back(e);
      end
   endtask

   task automatic set_t1();
      rp[0] = 0;
      rp[1] = 1;
      rp[2] = 1;
      for (int i = 3; i <= NR; i++) rp[i] = 3;
      ba = '{16'h4000, 16'h3C00, 16'h4000};
      bx = '{16'h4200, 16'h3C00, 16'h4000};
   endtask

   initial begin
      for (int i = 0; i < NR; i++) my[i] = 16'h0000;
      repeat (3) @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      rstq.push_back(1);

      set_t1();
      run_job(1'b0, 0);
      run_job(1'b1, 0);
      run_job(1'b0, 0);

      for (int i = 0; i <= NR; i++) rp[i] = 0;
      run_job(1'b0, 0);

      set_t1();
      run_job(1'b0, 3);

      rp[0] = 0;
      rp[1] = 2;
      for (int i = 2; i <= NR; i++) rp[i] = 1;
      run_job(1'b0, 0);

      // abort in the middle of a job
      wait_idle();
      for (int i = 0; i <= NR; i++) rp[i] = i;
      start_job(1'b0);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      send_beat(16'h4000, 16'h4000);
      send_beat(16'h3C00, 16'h4200);
      i_rstn = 1'b0;
      @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      rstq.push_back(1);
      for (int i = 0; i < NR; i++) my[i] = 16'h0000;
      set_t1();
      run_job(1'b0, 0);

      for (int j = 0; j < 30; j++) begin
         rp[0] = ($urandom_range(15, 0) == 0) ? 1 : 0;
         for (int i = 1; i <= NR; i++)
            rp[i] = rp[i-1] + $urandom_range(3, 0);
         if ($urandom_range(7, 0) == 0) begin
            int jj;
            jj = $urandom_range(NR - 1, 1);
            rp[jj] = rp[jj+1] + 1;
         end
         ba.delete();
         bx.delete();
         for (int k = 0; k < rp[NR] + 2; k++) begin
            ba.push_back(rnd_fp());
            bx.push_back(rnd_fp());
         end
         run_job(1'($urandom_range(1, 0)), 3);
      end

      wait_idle();
      repeat (5) @(posedge i_clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
